// File: rtl/octo_screen_scanner.sv
// octo_screen_scanner: sweeps screen coordinates, collects responder colour after a fixed latency and issues plot writes
module octo_screen_scanner #(
  parameter int H_RES = 320,
  parameter int V_RES = 240,
  parameter int LATENCY = 2,
  parameter logic [2:0] FG_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Enable,
  input  logic       Start,
  input  logic       Continuous,
  output logic [8:0] VGAx,
  output logic [7:0] VGAy,
  input  logic       VGAcol,
  output logic [8:0] PlotX,
  output logic [7:0] PlotY,
  output logic [2:0] PlotColour,
  output logic       Plot,
  output logic       Busy,
  output logic       FrameDone,
  output logic [7:0] FrameCount
);
  localparam int DW = $clog2(LATENCY + 1) + 1;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [8:0] x_q, x_d, plot_x_q, plot_x_d;
  logic [7:0] y_q, y_d, plot_y_q, plot_y_d, fc_q, fc_d;
  logic [DW-1:0] dc_q, dc_d;
  logic [2:0] colour_q, colour_d;
  logic plot_q, plot_d, busy_q, busy_d, done_q, done_d;
  logic [LATENCY-1:0] pv_q, pv_d;
  logic [LATENCY-1:0][8:0] px_q, px_d;
  logic [LATENCY-1:0][7:0] py_q, py_d;
  // Sweep FSM: raster coordinate counters, drain timer, frame bookkeeping; Enable low aborts to IDLE
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    dc_d = dc_q;
    fc_d = fc_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: state_d = (Start || Continuous) ? SCAN : IDLE;
      SCAN: begin
        x_d = (x_q == 9'(H_RES - 1)) ? 9'd0 : x_q + 9'd1;
        if (x_q == 9'(H_RES - 1)) begin
          y_d = (y_q == 8'(V_RES - 1)) ? 8'd0 : y_q + 8'd1;
          state_d = (y_q == 8'(V_RES - 1)) ? DRAIN : SCAN;
          dc_d = '0;
        end
      end
      DRAIN: begin
        dc_d = dc_q + 1'b1;
        if (dc_q == DW'(LATENCY)) begin
          done_d = 1'b1;
          fc_d = fc_q + 8'd1;
          state_d = Continuous ? SCAN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!Enable) begin
      state_d = IDLE;
      x_d = '0;
      y_d = '0;
      done_d = 1'b0;
      fc_d = fc_q;
    end
    busy_d = state_d != IDLE;
  end
  // Delay line tags each issued coordinate so its answer lands on the right plot write
  always_comb begin
    pv_d[0] = Enable && state_q == SCAN;
    px_d[0] = x_q;
    py_d[0] = y_q;
    for (int i = 1; i < LATENCY; i++) begin
      pv_d[i] = Enable && pv_q[i-1];
      px_d[i] = px_q[i-1];
      py_d[i] = py_q[i-1];
    end
    plot_d = Enable && pv_q[LATENCY-1];
    plot_x_d = px_q[LATENCY-1];
    plot_y_d = py_q[LATENCY-1];
    colour_d = VGAcol ? FG_COLOUR : BG_COLOUR;
  end
  // All state and outputs registered; asynchronous clear
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      dc_q <= '0;
      fc_q <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      pv_q <= '0;
      px_q <= '0;
      py_q <= '0;
      plot_q <= 1'b0;
      plot_x_q <= '0;
      plot_y_q <= '0;
      colour_q <= '0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      dc_q <= dc_d;
      fc_q <= fc_d;
      done_q <= done_d;
      busy_q <= busy_d;
      pv_q <= pv_d;
      px_q <= px_d;
      py_q <= py_d;
      plot_q <= plot_d;
      plot_x_q <= plot_x_d;
      plot_y_q <= plot_y_d;
      colour_q <= colour_d;
    end
  end
  assign VGAx = x_q;
  assign VGAy = y_q;
  assign PlotX = plot_x_q;
  assign PlotY = plot_y_q;
  assign PlotColour = colour_q;
  assign Plot = plot_q;
  assign Busy = busy_q;
  assign FrameDone = done_q;
  assign FrameCount = fc_q;
endmodule
